// File: rtl/axi2mem_pkg.sv
// axi2mem_pkg: default widths and the {id,last} meta entry for the axi2mem read channel
package axi2mem_pkg;
  localparam int AXI2MEM_DATA_WIDTH = 32;
  localparam int AXI2MEM_ADDR_WIDTH = 32;
  localparam int AXI2MEM_ID_WIDTH = 6;
  localparam int AXI2MEM_MAX_OUTSTANDING = 4;
  typedef struct packed {
    logic [AXI2MEM_ID_WIDTH-1:0] id;
    logic                        last;
  } axi2mem_meta_t;
endpackage

// File: rtl/axi2mem_sync_fifo.sv
// axi2mem_sync_fifo: synchronous FIFO, wrap-bit pointers tell full from empty
module axi2mem_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic push_ok, pop_ok;
  assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign empty_o = wr_q == rd_q;
  assign count_o = wr_q - rd_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign wr_d    = push_ok ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d    = pop_ok ? rd_q + (AW+1)'(1) : rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/axi2mem_tcdm_rd_if_mo.sv
// axi2mem_tcdm_rd_if_mo: credit-limited multi-outstanding TCDM read channel.
// AXI2MEM_RD_BYPASS_EN lets a response skip the empty data FIFO combinationally.
module axi2mem_tcdm_rd_if_mo import axi2mem_pkg::*; #(
  parameter int DATA_WIDTH      = AXI2MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH      = AXI2MEM_ADDR_WIDTH,
  parameter int ID_WIDTH        = AXI2MEM_ID_WIDTH,
  parameter int MAX_OUTSTANDING = AXI2MEM_MAX_OUTSTANDING
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    trans_req_i,
  output logic                    trans_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   trans_add_i,
  input  logic [ID_WIDTH-1:0]     trans_id_i,
  input  logic                    trans_last_i,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [DATA_WIDTH-1:0]   data_dat_o,
  output logic [ID_WIDTH-1:0]     data_id_o,
  output logic                    data_last_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_we_o,
  output logic [DATA_WIDTH-1:0]   tcdm_wdata_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i,
  input  logic                    tcdm_r_valid_i
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                last;
  } meta_t;
  meta_t meta_in, meta_head;
  logic [DATA_WIDTH-1:0] data_head;
  logic [CW-1:0] meta_cnt, data_cnt;
  logic meta_full, meta_empty, data_full, data_empty;
  logic rsp_ok, deliver, data_push;
  assign tcdm_req_o   = trans_req_i & ~meta_full;
  assign trans_gnt_o  = tcdm_req_o & tcdm_gnt_i;
  assign tcdm_add_o   = trans_add_i;
  assign tcdm_we_o    = 1'b1;
  assign tcdm_wdata_o = '0;
  assign tcdm_be_o    = {(DATA_WIDTH/8){tcdm_req_o}};
  assign meta_in      = '{id: trans_id_i, last: trans_last_i};
  // a response without a matching outstanding command is dropped
  assign rsp_ok       = tcdm_r_valid_i & (data_cnt < meta_cnt);
  assign deliver      = data_req_o & data_gnt_i;
`ifdef AXI2MEM_RD_BYPASS_EN
  logic bypass;
  assign bypass     = data_empty & rsp_ok;
  assign data_push  = rsp_ok & ~(bypass & data_gnt_i);
  assign data_req_o = ~data_empty | bypass;
  assign data_dat_o = bypass ? tcdm_r_rdata_i : data_empty ? '0 : data_head;
`else
  assign data_push  = rsp_ok;
  assign data_req_o = ~data_empty;
  assign data_dat_o = data_empty ? '0 : data_head;
`endif
  assign data_id_o   = data_req_o ? meta_head.id : '0;
  assign data_last_o = data_req_o & meta_head.last;
  axi2mem_sync_fifo #(.WIDTH(ID_WIDTH + 1), .DEPTH(MAX_OUTSTANDING)) u_meta (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (trans_gnt_o),
    .data_i  (meta_in),
    .pop_i   (deliver),
    .data_o  (meta_head),
    .full_o  (meta_full),
    .empty_o (meta_empty),
    .count_o (meta_cnt)
  );
  axi2mem_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_data (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (data_push),
    .data_i  (tcdm_r_rdata_i),
    .pop_i   (deliver),
    .data_o  (data_head),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (data_cnt)
  );
`ifndef SYNTHESIS
  a_rsp_credit: assert property (@(posedge clk_i) disable iff (rst_i) !(tcdm_r_valid_i && meta_cnt == data_cnt))
    else $error("r_valid with no outstanding read");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(data_push && data_full));
  a_meta_cover: assert property (@(posedge clk_i) disable iff (rst_i) !(data_req_o && meta_empty));
`endif
endmodule

// File: tb/tb_axi2mem_tcdm_rd_if_mo.sv
// tb_axi2mem_tcdm_rd_if_mo: scoreboard bench with a TCDM responder model
module tb_axi2mem_tcdm_rd_if_mo;
  localparam int MO = 4;
  logic clk = 1'b0, rst_i = 1'b1;
  logic trans_req_i = 1'b0, trans_gnt_o, trans_last_i = 1'b0;
  logic [31:0] trans_add_i = '0;
  logic [5:0] trans_id_i = '0;
  logic data_req_o, data_gnt_i = 1'b0, data_last_o;
  logic [31:0] data_dat_o;
  logic [5:0] data_id_o;
  logic tcdm_req_o, tcdm_gnt_i = 1'b0, tcdm_we_o, tcdm_r_valid_i = 1'b0;
  logic [31:0] tcdm_add_o, tcdm_wdata_o, tcdm_r_rdata_i = '0;
  logic [3:0] tcdm_be_o;
  always #5 clk = ~clk;
  axi2mem_tcdm_rd_if_mo dut (
    .clk_i(clk), .rst_i(rst_i),
    .trans_req_i(trans_req_i), .trans_gnt_o(trans_gnt_o), .trans_add_i(trans_add_i),
    .trans_id_i(trans_id_i), .trans_last_i(trans_last_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_dat_o(data_dat_o),
    .data_id_o(data_id_o), .data_last_o(data_last_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_we_o(tcdm_we_o), .tcdm_wdata_o(tcdm_wdata_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_r_rdata_i(tcdm_r_rdata_i), .tcdm_r_valid_i(tcdm_r_valid_i)
  );
  typedef struct {
    logic [31:0] addr;
    logic [5:0]  id;
    logic        last;
    logic [31:0] data;
  } cmd_t;
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  cmd_t cmd_q[$];
  cmd_t exp_q[$];
  rsp_t pend_q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, grants = 0, beats = 0, tb_meta = 0, tb_data = 0;
  int first_beat = -1, last_beat = -1;
  int p_tgnt = 100, p_dgnt = 100, lat_min = 1, lat_max = 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic add_cmd(input logic [31:0] addr, input logic [5:0] id, input logic last, input logic [31:0] data);
    cmd_t c;
    c.addr = addr; c.id = id; c.last = last; c.data = data;
    cmd_q.push_back(c);
  endtask
  task automatic step();
    logic rv, exp_req;
    cmd_t c, e;
    rsp_t r;
    trans_req_i = cmd_q.size() != 0;
    if (trans_req_i) begin
      trans_add_i = cmd_q[0].addr;
      trans_id_i = cmd_q[0].id;
      trans_last_i = cmd_q[0].last;
    end
    tcdm_gnt_i = $urandom_range(99) < p_tgnt;
    data_gnt_i = $urandom_range(99) < p_dgnt;
    rv = pend_q.size() != 0 && pend_q[0].due <= cyc;
    tcdm_r_valid_i = rv;
    tcdm_r_rdata_i = rv ? pend_q[0].data : '0;
    @(negedge clk);
    exp_req = trans_req_i && tb_meta < MO;
    chk("tcdm_req", 64'(tcdm_req_o), 64'(exp_req));
    chk("trans_gnt", 64'(trans_gnt_o), 64'(exp_req && tcdm_gnt_i));
    chk("data_req", 64'(data_req_o), 64'(tb_data != 0));
    if (tcdm_req_o) chk("tcdm_add", 64'(tcdm_add_o), 64'(trans_add_i));
    if (data_req_o && data_gnt_i) begin
      if (exp_q.size() == 0) chk("beat_unexpected", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("dat", 64'(data_dat_o), 64'(e.data));
        chk("id", 64'(data_id_o), 64'(e.id));
        chk("last", 64'(data_last_o), 64'(e.last));
      end
      beats++; tb_meta--; tb_data--;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    if (trans_gnt_o) begin
      c = cmd_q.pop_front();
      exp_q.push_back(c);
      r.data = c.data;
      r.due = cyc + $urandom_range(lat_max, lat_min);
      pend_q.push_back(r);
      grants++; tb_meta++;
    end
    if (rv) begin
      void'(pend_q.pop_front());
      tb_data++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(cmd_q.size() + exp_q.size()), 64'(0));
  endtask
  initial begin
    int g0, b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_data_req", 64'(data_req_o), 64'(0));
    chk("rst_data_dat", 64'(data_dat_o), 64'(0));
    chk("rst_data_id", 64'(data_id_o), 64'(0));
    chk("rst_data_last", 64'(data_last_o), 64'(0));
    chk("rst_tcdm_req", 64'(tcdm_req_o), 64'(0));
    chk("rst_be", 64'(tcdm_be_o), 64'(0));
    trans_req_i = 1'b1;
    #1;
    chk("rst_req_follow", 64'(tcdm_req_o), 64'(1));
    chk("rst_be_req", 64'(tcdm_be_o), 64'hF);
    chk("we", 64'(tcdm_we_o), 64'(1));
    chk("wdata", 64'(tcdm_wdata_o), 64'(0));
    trans_req_i = 1'b0;
    @(posedge clk);
    #1;
    // single beat
    b0 = beats;
    add_cmd(32'h100, 6'h2A, 1'b1, 32'hDEADBEEF);
    drain("single_drain", 20);
    repeat (3) step();
    chk("single_beats", 64'(beats - b0), 64'(1));
    // back-pressure fill
    p_dgnt = 0;
    g0 = grants; b0 = beats;
    for (int i = 0; i < 6; i++) add_cmd(32'h200 + 32'(i * 4), 6'(i + 1), i == 5, $urandom);
    repeat (10) step();
    chk("bp_grants", 64'(grants - g0), 64'(4));
    chk("bp_req_low", 64'(tcdm_req_o), 64'(0));
    chk("bp_pending_cmds", 64'(cmd_q.size()), 64'(2));
    p_dgnt = 100;
    drain("bp_drain", 40);
    chk("bp_beats", 64'(beats - b0), 64'(6));
    // streaming 16-beat burst
    b0 = beats; first_beat = -1;
    for (int i = 0; i < 16; i++) add_cmd(32'h1000 + 32'(i * 4), 6'h11, i == 15, $urandom);
    drain("stream_drain", 60);
    chk("stream_beats", 64'(beats - b0), 64'(16));
    chk("stream_span", 64'(last_beat - first_beat), 64'(15));
    // random stalls
    p_tgnt = 50; p_dgnt = 50; lat_min = 1; lat_max = 3;
    b0 = beats;
    for (int i = 0; i < 1000; i++) add_cmd($urandom, 6'($urandom), 1'($urandom), $urandom);
    drain("rand_drain", 20000);
    chk("rand_beats", 64'(beats - b0), 64'(1000));
    // reset with outstanding reads
    p_tgnt = 100; p_dgnt = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) add_cmd(32'h300 + 32'(i * 4), 6'h05, 1'b0, $urandom);
    repeat (4) step();
    chk("mid_outstanding", 64'(tb_meta), 64'(3));
    rst_i = 1'b1;
    trans_req_i = 1'b0; tcdm_gnt_i = 1'b0; data_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    cmd_q.delete(); exp_q.delete(); pend_q.delete();
    tb_meta = 0; tb_data = 0;
    #1;
    chk("post_rst_data_req", 64'(data_req_o), 64'(0));
    chk("post_rst_data_dat", 64'(data_dat_o), 64'(0));
    g0 = grants; b0 = beats;
    for (int i = 0; i < 5; i++) add_cmd(32'h400 + 32'(i * 4), 6'(i + 8), i == 4, $urandom);
    repeat (8) step();
    chk("post_rst_grants", 64'(grants - g0), 64'(4));
    p_dgnt = 100;
    drain("post_rst_drain", 40);
    chk("post_rst_beats", 64'(beats - b0), 64'(5));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
